demux_bank_seq: RTL



---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_onehot_dec.sv | 28 ++
 rtl/demux_bank_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types for the registered channel demux bank.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package demux_pkg;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_BCAST = 2'b01,
    MODE_AUTO  = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

endpackage

// File: rtl/demux_onehot_dec.sv
// Select-to-one-hot decoder with out-of-range flag for non power-of-two banks.
// Latency: combinational.
// Backpressure: none; pure function of sel.
module demux_onehot_dec
  import demux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [CHANNELS-1:0] onehot,
  output logic                oor
);

  // One extra bit so CHANNELS itself is representable when it is a power of two.
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

  // Raise exactly the enable of the selected channel; none when sel is past the bank.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      onehot[i] = (sel == SEL_W'(i));
    end
  end

  assign oor = ({1'b0, sel} >= NCH);

endmodule

// File: rtl/demux_bank_seq.sv
// Routes newval into a bank of CHANNELS registers: addressed, broadcast, auto-increment, sequential clear.
// Latency: 1 cycle from acceptance to D/written; clear occupies CHANNELS cycles.
// Backpressure: in_ready low for the whole clear, driven from state only.
module demux_bank_seq
  import demux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    S,
  input  logic [WIDTH-1:0]    newval,
  output logic [WIDTH-1:0]    D [CHANNELS-1:0],
  output logic [CHANNELS-1:0] written,
  output logic [SEL_W-1:0]    wr_ptr,
  output logic                err,
  output logic                clr_done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  state_t               state, state_nxt;
  mode_t                mode_e;
  logic [SEL_W-1:0]     clr_idx;
  logic                 accept;
  logic                 start_clr;
  logic                 last_clr;
  logic [SEL_W-1:0]     dec_sel;
  logic [CHANNELS-1:0]  dec_hot;
  logic                 dec_oor;
  logic [CHANNELS-1:0]  we;
  logic [WIDTH-1:0]     wval;
  logic                 wflag;
  logic                 err_nxt;
  logic                 ptr_adv;

  assign mode_e   = mode_t'(mode);
  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // One decoder serves all three indexed paths: clear index wins while clearing.
  assign dec_sel = (state == ST_CLEARING) ? clr_idx :
                   (mode_e == MODE_AUTO)  ? wr_ptr  : S;

  demux_onehot_dec #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_dec (
    .sel    (dec_sel),
    .onehot (dec_hot),
    .oor    (dec_oor)
  );

  // A reset landing on the final clear cycle must not leak a done pulse.
  assign clr_done = last_clr && !reset;

  // Next-state logic: enter CLEARING on an accepted clear, leave after the last channel.
  always_comb begin
    state_nxt = state;
    start_clr = 1'b0;
    last_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && mode_e == MODE_CLEAR) begin
          start_clr = 1'b1;
          state_nxt = ST_CLEARING;
        end
      end
      ST_CLEARING: begin
        if (clr_idx == LAST) begin
          last_clr  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-channel write enables and data for the current cycle.
  always_comb begin
    we      = '0;
    wval    = newval;
    wflag   = 1'b1;
    err_nxt = 1'b0;
    ptr_adv = 1'b0;
    if (state == ST_CLEARING) begin
      we    = dec_hot;
      wval  = '0;
      wflag = 1'b0;
    end else if (accept) begin
      case (mode_e)
        MODE_ADDR: begin
          we      = dec_oor ? '0 : dec_hot;
          err_nxt = dec_oor;
        end
        MODE_BCAST: we = '1;
        MODE_AUTO: begin
          we      = dec_hot;
          ptr_adv = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Channel bank, written flags, AUTO pointer, clear index and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) D[i] <= '0;
      written <= '0;
      wr_ptr  <= '0;
      clr_idx <= '0;
      err     <= 1'b0;
    end else begin
      err <= err_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        if (we[i]) begin
          D[i]       <= wval;
          written[i] <= wflag;
        end
      end
      if (last_clr)     wr_ptr <= '0;
      else if (ptr_adv) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + SEL_W'(1);
      if (start_clr)                 clr_idx <= '0;
      else if (state == ST_CLEARING) clr_idx <= last_clr ? '0 : clr_idx + SEL_W'(1);
    end
  end

endmodule
